reg_rename_file: RTL

// - Architectural register file plus rename table, directly downstream of the ROB commit port.
// - Issue marks rd busy with the allocating ROB id. ROB commit writes the value and clears busy when the tag matches.
// - Issue reads rs1/rs2 to get either a committed value or the ROB id to wait on.
// - A predict-fail flush clears every rename tag.

---
 rtl/reg_rename_file_pkg.sv | 19 +
 rtl/reg_rename_file_if.sv | 41 ++++
 rtl/reg_rename_file_rrf_read_port.sv | 36 +++
 rtl/reg_rename_file.sv | 83 ++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
// Shared sizing, index/tag/word types and the x0 constant for the register rename file.
package reg_rename_file_pkg;

  localparam int ROB_SIZE_LOG = 4;
  localparam int REG_NUM      = 32;
  localparam int REG_IDX_W    = $clog2(REG_NUM);
  localparam int XLEN         = 32;

  typedef logic [ROB_SIZE_LOG-1:0] rob_id_t;
  typedef logic [REG_IDX_W-1:0]    reg_idx_t;
  typedef logic [XLEN-1:0]         word_t;

  localparam reg_idx_t REG_ZERO = '0;

  function automatic logic is_zero_reg(reg_idx_t r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_rename_file_if.sv
// Issue/commit/read bundle between the issue stage, the ROB commit port and the rename file.
interface reg_rename_file_if;
  import reg_rename_file_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_rd;
  rob_id_t  issue_robid;

  reg_idx_t rs1_idx;
  reg_idx_t rs2_idx;
  logic     rs1_busy;
  logic     rs2_busy;
  rob_id_t  rs1_robid;
  rob_id_t  rs2_robid;
  word_t    rs1_value;
  word_t    rs2_value;

  logic     commit_enable;
  reg_idx_t commit_regid;
  word_t    commit_value;
  rob_id_t  commit_robid;

  logic     pred_fail_flag;

  modport master (
    output issue_valid, issue_rd, issue_robid,
    output rs1_idx, rs2_idx,
    input  rs1_busy, rs2_busy, rs1_robid, rs2_robid, rs1_value, rs2_value,
    output commit_enable, commit_regid, commit_value, commit_robid,
    output pred_fail_flag
  );

  modport slave (
    input  issue_valid, issue_rd, issue_robid,
    input  rs1_idx, rs2_idx,
    output rs1_busy, rs2_busy, rs1_robid, rs2_robid, rs1_value, rs2_value,
    input  commit_enable, commit_regid, commit_value, commit_robid,
    input  pred_fail_flag
  );

endinterface

// File: rtl/reg_rename_file_rrf_read_port.sv
// One combinational source-operand read: x0 forcing, same-cycle commit bypass, else table lookup.
module rrf_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_idx_t             idx,
  input  logic [REG_NUM-1:0]   busy_vec,
  input  rob_id_t              tag_arr   [REG_NUM],
  input  word_t                value_arr [REG_NUM],
  input  logic                 commit_live,
  input  reg_idx_t             commit_regid,
  input  word_t                commit_value,
  input  rob_id_t              commit_robid,
  output logic                 busy,
  output rob_id_t              robid,
  output word_t                value
);

  always_comb begin
    busy  = 1'b0;
    robid = '0;
    value = '0;
    if (!is_zero_reg(idx)) begin
      robid = tag_arr[idx];
      // A commit landing this cycle for the newest producer resolves the operand immediately.
      if (commit_live && commit_regid == idx && busy_vec[idx] &&
          tag_arr[idx] == commit_robid) begin
        busy  = 1'b0;
        value = commit_value;
      end else begin
        busy  = busy_vec[idx];
        value = value_arr[idx];
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename tags; issue renames rd, ROB commit retires values.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  reg_rename_file_if.slave     bus
);

  word_t              value_q [REG_NUM];
  word_t              value_d [REG_NUM];
  rob_id_t            tag_q   [REG_NUM];
  rob_id_t            tag_d   [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  logic commit_live;
  logic issue_live;

  assign commit_live = rdy && bus.commit_enable;
  assign issue_live  = rdy && bus.issue_valid && !bus.pred_fail_flag &&
                       !is_zero_reg(bus.issue_rd);

  // Statement order sets priority: flush overrides issue, issue overrides commit-clear.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (commit_live && !is_zero_reg(bus.commit_regid)) begin
      value_d[bus.commit_regid] = bus.commit_value;
      if (busy_q[bus.commit_regid] && tag_q[bus.commit_regid] == bus.commit_robid)
        busy_d[bus.commit_regid] = 1'b0;
    end
    if (rdy && bus.pred_fail_flag) begin
      busy_d = '0;
    end else if (issue_live) begin
      busy_d[bus.issue_rd] = 1'b1;
      tag_d[bus.issue_rd]  = bus.issue_robid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '{default: '0};
      tag_q   <= '{default: '0};
      busy_q  <= '0;
    end else if (rdy) begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  rrf_read_port u_rs1 (
    .idx          (bus.rs1_idx),
    .busy_vec     (busy_q),
    .tag_arr      (tag_q),
    .value_arr    (value_q),
    .commit_live  (commit_live),
    .commit_regid (bus.commit_regid),
    .commit_value (bus.commit_value),
    .commit_robid (bus.commit_robid),
    .busy         (bus.rs1_busy),
    .robid        (bus.rs1_robid),
    .value        (bus.rs1_value)
  );

  rrf_read_port u_rs2 (
    .idx          (bus.rs2_idx),
    .busy_vec     (busy_q),
    .tag_arr      (tag_q),
    .value_arr    (value_q),
    .commit_live  (commit_live),
    .commit_regid (bus.commit_regid),
    .commit_value (bus.commit_value),
    .commit_robid (bus.commit_robid),
    .busy         (bus.rs2_busy),
    .robid        (bus.rs2_robid),
    .value        (bus.rs2_value)
  );

endmodule
